// File: rtl/fc_sequencer_if.sv
// Bus between the FC sequencer and its environment: CNN start pulse, single-port
// weight/data RAM read port, and the classification result handshake.
interface fc_sequencer_if #(
   parameter int WORD_SIZE  = 16,
   parameter int ADDR_WIDTH = 16
) ();
   logic                  start;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic                  ram_rd_en;
   logic [WORD_SIZE-1:0]  ram_rd_data;
   logic                  busy;
   logic                  done;
   logic [3:0]            result;

   modport master (
      input  start, ram_rd_data,
      output ram_addr, ram_rd_en, busy, done, result
   );

   modport slave (
      output start, ram_rd_data,
      input  ram_addr, ram_rd_en, busy, done, result
   );
endinterface

// File: rtl/fc_sequencer.sv
// Time-multiplexed two-layer fully connected classifier: one shared MAC, an input
// buffer, a hidden buffer, and a running argmax over the layer-2 outputs.
module fc_sequencer #(
   parameter int WORD_SIZE      = 16,
   parameter int INT_SLICE      = 8,
   parameter int IP_LAYER1_SIZE = 128,
   parameter int OP_LAYER1_SIZE = 84,
   parameter int OP_LAYER2_SIZE = 10,
   parameter int ADDR_WIDTH     = 16,
   parameter int X_BASE         = 0,
   parameter int W1_BASE        = 128,
   parameter int B1_BASE        = 10880,
   parameter int W2_BASE        = 10964,
   parameter int B2_BASE        = 11804
) (
   input logic             clk,
   input logic             rst_n,
   fc_sequencer_if.master  bus
);
   localparam int FRAC = WORD_SIZE - INT_SLICE;
   localparam int PW   = 2 * WORD_SIZE;
   localparam int AW   = 2 * WORD_SIZE + 8;
   localparam int CW   = $clog2(IP_LAYER1_SIZE + OP_LAYER1_SIZE + 4);
   localparam int JMAX = (OP_LAYER1_SIZE > OP_LAYER2_SIZE) ? OP_LAYER1_SIZE : OP_LAYER2_SIZE;
   localparam int JW   = $clog2(JMAX + 1);
   localparam int XIW  = (IP_LAYER1_SIZE > 1) ? $clog2(IP_LAYER1_SIZE) : 1;
   localparam int HIW  = (OP_LAYER1_SIZE > 1) ? $clog2(OP_LAYER1_SIZE) : 1;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD_X = 3'd1;
   localparam logic [2:0] ST_L1     = 3'd2;
   localparam logic [2:0] ST_L2     = 3'd3;
   localparam logic [2:0] ST_FINISH = 3'd4;

   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_TWO  = CW'(2);
   localparam logic [CW-1:0] IN1_C    = CW'(IP_LAYER1_SIZE);
   localparam logic [CW-1:0] N1_C     = CW'(OP_LAYER1_SIZE);
   localparam logic [JW-1:0] J_ZERO   = {JW{1'b0}};
   localparam logic [JW-1:0] J_ONE    = JW'(1);
   localparam logic [JW-1:0] J1_LAST  = JW'(OP_LAYER1_SIZE - 1);
   localparam logic [JW-1:0] J2_LAST  = JW'(OP_LAYER2_SIZE - 1);

   localparam logic [ADDR_WIDTH-1:0] X_A  = ADDR_WIDTH'(X_BASE);
   localparam logic [ADDR_WIDTH-1:0] W1_A = ADDR_WIDTH'(W1_BASE);
   localparam logic [ADDR_WIDTH-1:0] B1_A = ADDR_WIDTH'(B1_BASE);
   localparam logic [ADDR_WIDTH-1:0] W2_A = ADDR_WIDTH'(W2_BASE);
   localparam logic [ADDR_WIDTH-1:0] B2_A = ADDR_WIDTH'(B2_BASE);

   localparam logic signed [AW-1:0] SAT_MAX = {{(AW-WORD_SIZE+1){1'b0}}, {(WORD_SIZE-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = {{(AW-WORD_SIZE+1){1'b1}}, {(WORD_SIZE-1){1'b0}}};

   function automatic logic signed [WORD_SIZE-1:0] sat_word(input logic signed [AW-1:0] a);
      logic signed [AW-1:0] s;
      s = a >>> FRAC;
      if (s > SAT_MAX) begin
         return SAT_MAX[WORD_SIZE-1:0];
      end else if (s < SAT_MIN) begin
         return SAT_MIN[WORD_SIZE-1:0];
      end else begin
         return s[WORD_SIZE-1:0];
      end
   endfunction

   logic [2:0]                   state_q, state_d;
   logic [CW-1:0]                cnt_q, cnt_d;
   logic [JW-1:0]                j_q, j_d;
   logic signed [AW-1:0]         acc_q, acc_d;
   logic [ADDR_WIDTH-1:0]        wptr_q, wptr_d;
   logic signed [WORD_SIZE-1:0]  best_val_q, best_val_d;
   logic [3:0]                   best_idx_q, best_idx_d;
   logic                         busy_q, busy_d;
   logic                         done_q, done_d;
   logic [3:0]                   result_q, result_d;
   logic [ADDR_WIDTH-1:0]        ram_addr_q, ram_addr_d;
   logic                         ram_rd_en_q, ram_rd_en_d;
   logic [WORD_SIZE-1:0]         x_buf_q [IP_LAYER1_SIZE];
   logic [WORD_SIZE-1:0]         h_buf_q [OP_LAYER1_SIZE];

   logic                         x_we_s, h_we_s;
   logic [CW-1:0]                in_len_s, nlen_s;
   logic [WORD_SIZE-1:0]         in_val_s;
   logic signed [PW-1:0]         prod_s;
   logic signed [AW-1:0]         prod_ext_s, bias_ext_s;
   logic signed [WORD_SIZE-1:0]  out_s, relu_s;

   assign in_len_s   = (state_q == ST_L1) ? IN1_C : N1_C;
   assign in_val_s   = (state_q == ST_L1) ? x_buf_q[XIW'(cnt_q - CNT_TWO)]
                                          : h_buf_q[HIW'(cnt_q - CNT_TWO)];
   assign prod_s     = $signed({{WORD_SIZE{bus.ram_rd_data[WORD_SIZE-1]}}, bus.ram_rd_data}) *
                       $signed({{WORD_SIZE{in_val_s[WORD_SIZE-1]}}, in_val_s});
   assign prod_ext_s = {{(AW-PW){prod_s[PW-1]}}, prod_s};
   assign bias_ext_s = {{(AW-WORD_SIZE){bus.ram_rd_data[WORD_SIZE-1]}}, bus.ram_rd_data} << FRAC;
   assign out_s      = sat_word(acc_q);
   assign relu_s     = out_s[WORD_SIZE-1] ? {WORD_SIZE{1'b0}} : out_s;

   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_rd_en = ram_rd_en_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.result    = result_q;

   // Next-state, MAC and argmax logic; the RAM port is computed one cycle ahead so it can be registered.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      j_d         = j_q;
      acc_d       = acc_q;
      wptr_d      = wptr_q;
      best_val_d  = best_val_q;
      best_idx_d  = best_idx_q;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      result_d    = result_q;
      x_we_s      = 1'b0;
      h_we_s      = 1'b0;
      ram_rd_en_d = 1'b0;
      ram_addr_d  = ram_addr_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_LOAD_X;
               cnt_d   = CNT_ZERO;
               j_d     = J_ZERO;
               acc_d   = {AW{1'b0}};
               wptr_d  = W1_A;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD_X: begin
            busy_d = 1'b1;
            x_we_s = (cnt_q != CNT_ZERO);
            if (cnt_q == IN1_C) begin
               state_d = ST_L1;
               cnt_d   = CNT_ZERO;
               j_d     = J_ZERO;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_L1, ST_L2: begin
            busy_d = 1'b1;
            if (cnt_q == CNT_ONE) begin
               acc_d = bias_ext_s;
            end else if ((cnt_q >= CNT_TWO) && (cnt_q <= in_len_s + CNT_ONE)) begin
               acc_d = acc_q + prod_ext_s;
            end else begin
               acc_d = acc_q;
            end
            if (cnt_q == in_len_s + CNT_TWO) begin
               cnt_d = CNT_ZERO;
               if (state_q == ST_L1) begin
                  h_we_s = 1'b1;
                  if (j_q == J1_LAST) begin
                     state_d = ST_L2;
                     j_d     = J_ZERO;
                     wptr_d  = W2_A;
                  end else begin
                     j_d = j_q + J_ONE;
                  end
               end else begin
                  // Strict compare so ties keep the lower class index.
                  if ((j_q == J_ZERO) || (out_s > best_val_q)) begin
                     best_val_d = out_s;
                     best_idx_d = 4'(j_q);
                  end else begin
                     best_val_d = best_val_q;
                  end
                  if (j_q == J2_LAST) begin
                     state_d = ST_FINISH;
                  end else begin
                     j_d = j_q + J_ONE;
                  end
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_FINISH: begin
            done_d   = 1'b1;
            result_d = best_idx_q;
            state_d  = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      nlen_s = (state_d == ST_L1) ? IN1_C : N1_C;
      if ((state_d == ST_LOAD_X) && (cnt_d < IN1_C)) begin
         ram_rd_en_d = 1'b1;
         ram_addr_d  = X_A + ADDR_WIDTH'(cnt_d);
      end else if (((state_d == ST_L1) || (state_d == ST_L2)) && (cnt_d == CNT_ZERO)) begin
         ram_rd_en_d = 1'b1;
         ram_addr_d  = ((state_d == ST_L1) ? B1_A : B2_A) + ADDR_WIDTH'(j_d);
      end else if (((state_d == ST_L1) || (state_d == ST_L2)) && (cnt_d <= nlen_s)) begin
         ram_rd_en_d = 1'b1;
         ram_addr_d  = wptr_q;
         wptr_d      = wptr_q + ADDR_WIDTH'(1);
      end else begin
         ram_rd_en_d = 1'b0;
      end
   end

   // Control state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= CNT_ZERO;
         j_q         <= J_ZERO;
         acc_q       <= {AW{1'b0}};
         wptr_q      <= {ADDR_WIDTH{1'b0}};
         best_val_q  <= {WORD_SIZE{1'b0}};
         best_idx_q  <= 4'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         result_q    <= 4'd0;
         ram_addr_q  <= {ADDR_WIDTH{1'b0}};
         ram_rd_en_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         j_q         <= j_d;
         acc_q       <= acc_d;
         wptr_q      <= wptr_d;
         best_val_q  <= best_val_d;
         best_idx_q  <= best_idx_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         result_q    <= result_d;
         ram_addr_q  <= ram_addr_d;
         ram_rd_en_q <= ram_rd_en_d;
      end
   end

   // Buffers are fully rewritten before every use, so they carry no reset.
   always_ff @(posedge clk) begin
      if (x_we_s) begin
         x_buf_q[XIW'(cnt_q - CNT_ONE)] <= bus.ram_rd_data;
      end
      if (h_we_s) begin
         h_buf_q[HIW'(j_q)] <= relu_s;
      end
   end
endmodule

// File: tb/tb_fc_sequencer.sv
// Scoreboard bench for fc_sequencer on a small 4-3-2 network with a 1-cycle RAM model.
module tb_fc_sequencer;
   localparam int IN1 = 4, N1 = 3, N2 = 2;
   localparam int XB = 0, W1B = 4, B1B = 16, W2B = 19, B2B = 25;
   localparam int RUN_LAT = 39, BUSY_LEN = 38, RD_PER_RUN = 27;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fc_sequencer_if #(.WORD_SIZE(16), .ADDR_WIDTH(16)) sif ();

   fc_sequencer #(
      .WORD_SIZE(16), .INT_SLICE(8), .IP_LAYER1_SIZE(IN1), .OP_LAYER1_SIZE(N1),
      .OP_LAYER2_SIZE(N2), .ADDR_WIDTH(16), .X_BASE(XB), .W1_BASE(W1B),
      .B1_BASE(B1B), .W2_BASE(W2B), .B2_BASE(B2B)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(sif)
   );

   logic [15:0] mem [0:255];
   int n_checks = 0, n_errors = 0;
   int cyc = 0, busy_cnt = 0, rd_cnt = 0;
   logic [3:0]  exp_q [$];
   int          start_q [$];
   logic [15:0] addr_q [$];

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (sif.ram_rd_en) sif.ram_rd_data <= mem[sif.ram_addr[7:0]];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic longint sat16(input longint v);
      if (v > 32767) return 32767;
      else if (v < -32768) return -32768;
      else return v;
   endfunction

   // Reference classifier computed from the RAM image.
   function automatic logic [3:0] model();
      longint acc, s, best;
      longint h [N1];
      logic [3:0] idx;
      best = 0;
      idx = 4'd0;
      for (int j = 0; j < N1; j++) begin
         acc = longint'($signed(mem[B1B+j])) * 256;
         for (int i = 0; i < IN1; i++)
            acc += longint'($signed(mem[W1B+j*IN1+i])) * longint'($signed(mem[XB+i]));
         s = sat16(acc >>> 8);
         h[j] = (s < 0) ? 0 : s;
      end
      for (int j = 0; j < N2; j++) begin
         acc = longint'($signed(mem[B2B+j])) * 256;
         for (int i = 0; i < N1; i++)
            acc += longint'($signed(mem[W2B+j*N1+i])) * h[i];
         s = sat16(acc >>> 8);
         if (j == 0 || s > best) begin
            best = s;
            idx = 4'(j);
         end
      end
      return idx;
   endfunction

   task automatic push_addrs();
      for (int i = 0; i < IN1; i++) addr_q.push_back(16'(XB + i));
      for (int j = 0; j < N1; j++) begin
         addr_q.push_back(16'(B1B + j));
         for (int i = 0; i < IN1; i++) addr_q.push_back(16'(W1B + j*IN1 + i));
      end
      for (int j = 0; j < N2; j++) begin
         addr_q.push_back(16'(B2B + j));
         for (int i = 0; i < N1; i++) addr_q.push_back(16'(W2B + j*N1 + i));
      end
   endtask

   task automatic fill(input logic [15:0] xv, w1v, b1v, w2r0, w2r1, b20, b21);
      for (int i = 0; i < IN1; i++) mem[XB+i] = xv;
      for (int i = 0; i < IN1*N1; i++) mem[W1B+i] = w1v;
      for (int j = 0; j < N1; j++) mem[B1B+j] = b1v;
      for (int i = 0; i < N1; i++) begin
         mem[W2B+i] = w2r0;
         mem[W2B+N1+i] = w2r1;
      end
      mem[B2B] = b20;
      mem[B2B+1] = b21;
   endtask

   // Called at a negedge; start is sampled on the following posedge.
   task automatic launch(input logic [3:0] e, input bit hold);
      exp_q.push_back(e);
      start_q.push_back(cyc + 1);
      push_addrs();
      sif.start = 1'b1;
      if (!hold) begin
         @(negedge clk);
         sif.start = 1'b0;
      end
   endtask

   task automatic wait_done(input int budget);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (sif.done) begin
            seen = 1'b1;
            break;
         end
      end
      check("done_seen", seen, 1);
   endtask

   // Output monitor: pops the scoreboard on every RAM read and every done pulse.
   always @(negedge clk) begin
      if (rst_n) begin
         if (sif.busy) busy_cnt <= busy_cnt + 1;
         if (sif.ram_rd_en) begin
            rd_cnt <= rd_cnt + 1;
            check("read_expected", addr_q.size() > 0, 1);
            if (addr_q.size() > 0) check("ram_addr", sif.ram_addr, addr_q.pop_front());
         end
         if (sif.done) begin
            check("busy_at_done", sif.busy, 0);
            check("done_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               check("result", sif.result, exp_q.pop_front());
               check("latency", cyc - start_q.pop_front(), RUN_LAT);
            end
            check("busy_cycles", busy_cnt, BUSY_LEN);
            check("rd_count", rd_cnt, RD_PER_RUN);
            busy_cnt <= 0;
            rd_cnt <= 0;
         end
      end else begin
         busy_cnt <= 0;
         rd_cnt <= 0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      sif.start = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      repeat (3) @(negedge clk);
      check("rst_ram_addr", sif.ram_addr, 0);
      check("rst_rd_en", sif.ram_rd_en, 0);
      check("rst_busy", sif.busy, 0);
      check("rst_done", sif.done, 0);
      check("rst_result", sif.result, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      fill(16'h0100, 16'h0100, 16'h0000, 16'h0080, 16'h0100, 16'h0000, 16'h0000);
      launch(4'd1, 1'b0); wait_done(100); @(negedge clk);

      fill(16'h0100, 16'h0100, 16'h0000, 16'h0100, 16'h0100, 16'h0000, 16'h0000);
      launch(4'd0, 1'b0); wait_done(100); @(negedge clk);

      fill(16'h7F00, 16'h7F00, 16'h0000, 16'h0000, 16'h0000, 16'h7F00, 16'h0000);
      mem[W2B+N1] = 16'h0100;
      launch(4'd1, 1'b0); wait_done(100); @(negedge clk);

      fill(16'h0100, 16'h0000, 16'hF000, 16'h0000, 16'h0000, 16'h0000, 16'hFF00);
      mem[W2B] = 16'h0100;
      launch(4'd0, 1'b0); wait_done(100); @(negedge clk);

      fill(16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'hFE00, 16'hFF00);
      launch(4'd1, 1'b0); wait_done(100); @(negedge clk);

      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 27; i++) mem[i] = 16'($urandom);
         launch(model(), 1'b0); wait_done(100); @(negedge clk);
      end

      // Back-to-back: second start in the cycle right after done.
      fill(16'h0100, 16'h0100, 16'h0000, 16'h0100, 16'h0100, 16'h0000, 16'h0000);
      launch(4'd0, 1'b0); wait_done(100);
      fill(16'h0100, 16'h0100, 16'h0000, 16'h0080, 16'h0100, 16'h0000, 16'h0000);
      launch(4'd1, 1'b0); wait_done(100); @(negedge clk);

      // Reset in the middle of layer 1.
      check("result_held", sif.result, 1);
      fill(16'h0100, 16'h0100, 16'h0000, 16'h0100, 16'h0100, 16'h0000, 16'h0000);
      launch(4'd0, 1'b0);
      repeat (12) @(negedge clk);
      check("pre_rst_busy", sif.busy, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_rd_en", sif.ram_rd_en, 0);
      check("midrst_busy", sif.busy, 0);
      check("midrst_done", sif.done, 0);
      check("midrst_result", sif.result, 0);
      check("midrst_addr", sif.ram_addr, 0);
      exp_q.delete(); start_q.delete(); addr_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (50) @(negedge clk);
      check("post_rst_idle", sif.busy, 0);
      fill(16'h0100, 16'h0100, 16'h0000, 16'h0080, 16'h0100, 16'h0000, 16'h0000);
      launch(4'd1, 1'b0); wait_done(100); @(negedge clk);

      // start held high and re-pulsed during a run: exactly one done.
      fill(16'h0100, 16'h0100, 16'h0000, 16'h0100, 16'h0100, 16'h0000, 16'h0000);
      launch(4'd0, 1'b1);
      repeat (10) @(negedge clk);
      sif.start = 1'b0;
      @(negedge clk);
      sif.start = 1'b1;
      wait_done(100);
      sif.start = 1'b0;
      repeat (50) @(negedge clk);
      check("no_extra_run", sif.busy, 0);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
